decoder_3to8_spec: RTL and testbench

DECODER_3TO8_SPEC -- requirements
Module: decoder_3to8

---
 rtl/decoder_3to8_spec.sv | 63 ++++++
 tb/tb_decoder_3to8_spec.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/decoder_3to8_spec.sv
`default_nettype none
// ============================================================================
// Module  : decoder_3to8_spec
// Brief   : 3-to-8 one-hot decoder, optional output register and inversion.
// Revision: 1.0 - initial release
// ============================================================================
module decoder_3to8_spec #(
    parameter bit OUT_REG        = 1'b1,
    parameter bit ACTIVE_LOW_OUT = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic adr0,
    input  logic adr1,
    input  logic adr2,
    input  logic E,
    output logic Y0,
    output logic Y1,
    output logic Y2,
    output logic Y3,
    output logic Y4,
    output logic Y5,
    output logic Y6,
    output logic Y7
);

    logic [2:0] w_idx;
    logic [7:0] dec_d;
    logic [7:0] w_line;
    logic [7:0] w_out;

    assign w_idx = {adr2, adr1, adr0};

    // Shifting by an unknown index yields X in simulation instead of picking a line.
    assign dec_d = {8{E}} & (8'd1 << w_idx);

    generate
        if (OUT_REG) begin : g_reg
            logic [7:0] dec_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dec_q <= 8'd0;
                end else begin
                    dec_q <= dec_d;
                end
            end

            assign w_line = dec_q;
        end else begin : g_comb
            logic w_unused_clk_rst;

            assign w_unused_clk_rst = clk ^ rst_n;
            assign w_line           = dec_d;
        end
    endgenerate

    assign w_out = ACTIVE_LOW_OUT ? ~w_line : w_line;

    assign {Y7, Y6, Y5, Y4, Y3, Y2, Y1, Y0} = w_out;

endmodule
`default_nettype wire

// File: tb/tb_decoder_3to8_spec.sv
`default_nettype none
// ============================================================================
// Module  : tb_decoder_3to8_spec
// Brief   : Directed self-checking bench for decoder_3to8_spec (three configs).
// Revision: 1.0 - initial release
// ============================================================================
module tb_decoder_3to8_spec;

    logic       clk;
    logic       clk_run;
    logic       rst_n;
    logic [2:0] adr;
    logic       en;

    logic [7:0] y;
    logic [7:0] y_al;
    logic [7:0] y_comb;

    int checks;
    int errors;

    decoder_3to8_spec u_dut (
        .clk(clk), .rst_n(rst_n),
        .adr0(adr[0]), .adr1(adr[1]), .adr2(adr[2]), .E(en),
        .Y0(y[0]), .Y1(y[1]), .Y2(y[2]), .Y3(y[3]),
        .Y4(y[4]), .Y5(y[5]), .Y6(y[6]), .Y7(y[7])
    );

    decoder_3to8_spec #(.OUT_REG(1'b1), .ACTIVE_LOW_OUT(1'b1)) u_dut_al (
        .clk(clk), .rst_n(rst_n),
        .adr0(adr[0]), .adr1(adr[1]), .adr2(adr[2]), .E(en),
        .Y0(y_al[0]), .Y1(y_al[1]), .Y2(y_al[2]), .Y3(y_al[3]),
        .Y4(y_al[4]), .Y5(y_al[5]), .Y6(y_al[6]), .Y7(y_al[7])
    );

    decoder_3to8_spec #(.OUT_REG(1'b0), .ACTIVE_LOW_OUT(1'b0)) u_dut_comb (
        .clk(clk), .rst_n(rst_n),
        .adr0(adr[0]), .adr1(adr[1]), .adr2(adr[2]), .E(en),
        .Y0(y_comb[0]), .Y1(y_comb[1]), .Y2(y_comb[2]), .Y3(y_comb[3]),
        .Y4(y_comb[4]), .Y5(y_comb[5]), .Y6(y_comb[6]), .Y7(y_comb[7])
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %02h expected %02h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge so the rising edge samples them cleanly.
    task automatic drive(input logic e, input logic [2:0] a);
        @(negedge clk);
        en  = e;
        adr = a;
    endtask

    task automatic edge_settle;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        clk_run = 1'b1;
        rst_n   = 1'b0;
        en      = 1'b0;
        adr     = 3'd0;

        #2;
        chk("reset_pre_edge", y, 8'h00);
        chk("reset_al", y_al, 8'hFF);
        edge_settle();
        chk("reset_held", y, 8'h00);

        @(negedge clk);
        rst_n = 1'b1;

        // Disabled: every address decodes to nothing
        for (int n = 0; n < 8; n++) begin
            drive(1'b0, 3'(n));
            edge_settle();
            chk($sformatf("dis_adr%0d", n), y, 8'h00);
        end

        // Enabled sweep with one-cycle latency
        for (int n = 0; n < 8; n++) begin
            drive(1'b1, 3'(n));
            #1;
            chk($sformatf("comb_adr%0d", n), y_comb, 8'h01 << n);
            if (n == 0) chk("hold_before_edge0", y, 8'h00);
            else        chk($sformatf("hold_before_edge%0d", n), y, 8'h01 << (n - 1));
            edge_settle();
            chk($sformatf("en_adr%0d", n), y, 8'h01 << n);
            chk($sformatf("al_adr%0d", n), y_al, ~(8'h01 << n));
        end

        // Explicit example: index 5
        drive(1'b1, 3'd5);
        edge_settle();
        chk("example_idx5", y, 8'h20);

        // Async reset between edges at index 3
        drive(1'b1, 3'd3);
        edge_settle();
        chk("idx3_settled", y, 8'h08);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_y", y, 8'h00);
        chk("async_rst_al", y_al, 8'hFF);
        chk("async_rst_comb", y_comb, 8'h08);
        edge_settle();
        chk("rst_ignores_edge", y, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release_no_edge", y, 8'h00);
        edge_settle();
        chk("release_first_edge", y, 8'h08);

        // E and address changing together
        drive(1'b1, 3'd6);
        edge_settle();
        chk("idx6", y, 8'h40);
        drive(1'b0, 3'd2);
        edge_settle();
        chk("same_edge_off", y, 8'h00);
        edge_settle();
        chk("same_edge_next", y, 8'h00);

        // Active-low at index 7
        drive(1'b1, 3'd7);
        edge_settle();
        chk("al_idx7", y_al, 8'h7F);

        // Combinational config with the clock stopped
        @(negedge clk);
        clk_run = 1'b0;
        #20;
        en  = 1'b1;
        adr = 3'd4;
        #1;
        chk("comb_stopped_idx4", y_comb, 8'h10);
        chk("reg_stopped_holds", y, 8'h80);
        rst_n = 1'b0;
        #1;
        chk("comb_rst_no_effect", y_comb, 8'h10);
        chk("reg_rst_stopped", y, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
